// File: rtl/usr_shift_ctrl_if.sv
// Command handshake bundle between a host FSM and usr_shift_ctrl.
// The host drives the master side; the controller uses the slave side.
interface usr_shift_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_fill;
  logic             cmd_rot;

  modport master (
    output cmd_valid, cmd_op, cmd_cnt, cmd_data, cmd_fill, cmd_rot,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_cnt, cmd_data, cmd_fill, cmd_rot,
    output cmd_ready
  );
endinterface

// File: rtl/usr_shift_ctrl.sv
// Command sequencer for a universal shift register: turns one handshaked command into
// the USR mode/serial/load drive sequence. Optional rotate support under macro ROTATE_EN.
module usr_shift_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  usr_shift_ctrl_if.slave  cmd,
  input  logic [WIDTH-1:0] usr_q,
  output logic [1:0]       usr_sel,
  output logic             usr_sl_r,
  output logic             usr_sl_l,
  output logic [WIDTH-1:0] usr_pi,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  logic [1:0]       state;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fill_q;
  logic             serial_bit;

`ifdef ROTATE_EN
  logic             rot_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rot_q <= 1'b0;
    end else if (state == ST_IDLE && cmd.cmd_valid) begin
      rot_q <= cmd.cmd_rot;
    end
  end

  // Rotation feeds the bit falling off the far end back in on the active side.
  always_comb begin
    serial_bit = fill_q;
    if (rot_q) begin
      serial_bit = (op_q == OP_SHR) ? usr_q[WIDTH-1] : usr_q[0];
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{usr_q, cmd.cmd_rot};
  assign serial_bit    = fill_q;
`endif

  // Command latch, parallel-load register and sequencing state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      op_q   <= OP_HOLD;
      cnt_q  <= '0;
      fill_q <= 1'b0;
      usr_pi <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd.cmd_valid) begin
            op_q   <= cmd.cmd_op;
            cnt_q  <= cmd.cmd_cnt;
            fill_q <= cmd.cmd_fill;
            case (cmd.cmd_op)
              OP_LOAD: begin
                usr_pi <= cmd.cmd_data;
                state  <= ST_LOAD;
              end
              OP_SHR, OP_SHL:
                state <= (cmd.cmd_cnt != '0) ? ST_SHIFT : ST_DONE;
              default:
                state <= ST_DONE;
            endcase
          end
        end
        ST_LOAD:
          state <= ST_DONE;
        ST_SHIFT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state <= ST_DONE;
          end
        end
        default:
          state <= ST_IDLE;
      endcase
    end
  end

  // USR drive decoded purely from registered state; only the active serial side is driven.
  always_comb begin
    usr_sel  = 2'b00;
    usr_sl_r = 1'b0;
    usr_sl_l = 1'b0;
    case (state)
      ST_LOAD:
        usr_sel = 2'b11;
      ST_SHIFT: begin
        usr_sel = op_q;
        if (op_q == OP_SHR) begin
          usr_sl_r = serial_bit;
        end else begin
          usr_sl_l = serial_bit;
        end
      end
      default: usr_sel = 2'b00;
    endcase
  end

  assign cmd.cmd_ready = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_DONE);

endmodule

// File: tb/tb_usr_shift_ctrl.sv
// Self-checking bench for usr_shift_ctrl with a behavioural USR and a reference model of
// the register contents; expectations follow ROTATE_EN if the bench is built with it.
module tb_usr_shift_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] usr_q;
  logic [1:0] usr_sel;
  logic       usr_sl_r;
  logic       usr_sl_l;
  logic [3:0] usr_pi;
  logic       busy;
  logic       done;

  int compared;
  int mismatched;
  logic [3:0] exp_q;

  usr_shift_ctrl_if #(.WIDTH(4), .CNT_W(3)) cmd_if ();

  usr_shift_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd_if),
    .usr_q    (usr_q),
    .usr_sel  (usr_sel),
    .usr_sl_r (usr_sl_r),
    .usr_sl_l (usr_sl_l),
    .usr_pi   (usr_pi),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The universal shift register being controlled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      usr_q <= 4'b0000;
    end else begin
      case (usr_sel)
        2'b01:   usr_q <= {usr_q[2:0], usr_sl_r};
        2'b10:   usr_q <= {usr_sl_l, usr_q[3:1]};
        2'b11:   usr_q <= usr_pi;
        default: usr_q <= usr_q;
      endcase
    end
  end

  function automatic bit rot_active(input bit rot);
`ifdef ROTATE_EN
    return rot;
`else
    return 1'b0;
`endif
  endfunction

  // Net effect of n shifts: rotation by n mod 4, or n fill bits entering from one end.
  function automatic logic [3:0] model_shift(input logic [3:0] q, input bit shr, input int n,
                                             input bit fill, input bit rot);
    int v;
    int r;
    int res;
    v = int'(q);
    if (rot) begin
      r = n % 4;
      res = shr ? ((v << r) | (v >> (4 - r))) : ((v >> r) | (v << (4 - r)));
    end else if (n >= 4) begin
      res = fill ? 15 : 0;
    end else if (shr) begin
      res = (v << n) | (fill ? ((1 << n) - 1) : 0);
    end else begin
      res = (v >> n) | (fill ? (15 << (4 - n)) : 0);
    end
    return 4'(res & 15);
  endfunction

  task automatic run_cmd(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] data,
                         input bit fill, input bit rot, input bit hold_valid, input string name);
    int exp_lat;
    int exp_hits;
    int lat;
    int sel_hits;
    int bad;
    bit seen;
    bit erot;
    logic [1:0] exp_sel;
    logic [3:0] exp_next;
    logic [3:0] q_done;
    erot     = rot_active(rot);
    exp_sel  = 2'b00;
    exp_hits = 0;
    exp_lat  = 1;
    exp_next = exp_q;
    if (op == 2'b11) begin
      exp_lat  = 2;
      exp_hits = 1;
      exp_sel  = 2'b11;
      exp_next = data;
    end else if (op != 2'b00 && cnt != 0) begin
      exp_lat  = int'(cnt) + 1;
      exp_hits = int'(cnt);
      exp_sel  = op;
      exp_next = model_shift(exp_q, op == 2'b01, int'(cnt), fill, erot);
    end

    @(negedge clk);
    cmd_if.cmd_op    = op;
    cmd_if.cmd_cnt   = cnt;
    cmd_if.cmd_data  = data;
    cmd_if.cmd_fill  = fill;
    cmd_if.cmd_rot   = rot;
    cmd_if.cmd_valid = 1'b1;
    compared++;
    if (cmd_if.cmd_ready !== 1'b1 || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL %s idle_before: ready=%b busy=%b, want ready=1 busy=0",
               name, cmd_if.cmd_ready, busy);
    end
    @(posedge clk);

    seen = 1'b0; lat = 0; sel_hits = 0; bad = 0; q_done = 4'bx;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (!hold_valid) cmd_if.cmd_valid = 1'b0;
      if (cmd_if.cmd_ready !== 1'b0 || busy !== 1'b1) bad++;
      if (usr_sel !== 2'b00) begin
        if (usr_sel === exp_sel) sel_hits++;
        else bad++;
      end
      if (usr_sel === 2'b11 && usr_pi !== data) bad++;
      if (usr_sel === 2'b01 &&
          (usr_sl_r !== (erot ? usr_q[3] : fill) || usr_sl_l !== 1'b0)) bad++;
      if (usr_sel === 2'b10 &&
          (usr_sl_l !== (erot ? usr_q[0] : fill) || usr_sl_r !== 1'b0)) bad++;
      if (done === 1'b1) begin
        seen = 1'b1;
        lat = k;
        q_done = usr_q;
        cmd_if.cmd_valid = 1'b0;
      end
    end

    compared++;
    if (!seen) begin
      mismatched++;
      $display("[TB] FAIL %s done_timeout: no done within 20 cycles, want done at +%0d",
               name, exp_lat);
      cmd_if.cmd_valid = 1'b0;
    end
    compared++;
    if (lat != exp_lat) begin
      mismatched++;
      $display("[TB] FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    compared++;
    if (q_done !== exp_next) begin
      mismatched++;
      $display("[TB] FAIL %s q_at_done: got %b want %b", name, q_done, exp_next);
    end
    compared++;
    if (sel_hits != exp_hits) begin
      mismatched++;
      $display("[TB] FAIL %s sel_cycles: got %0d want %0d (sel %b)", name, sel_hits, exp_hits, exp_sel);
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("[TB] FAIL %s busy_drive: got %0d bad cycles want 0", name, bad);
    end

    @(negedge clk);
    compared++;
    if (cmd_if.cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || usr_q !== exp_next) begin
      mismatched++;
      $display("[TB] FAIL %s after_done: ready=%b busy=%b done=%b q=%b, want 1 0 0 %b",
               name, cmd_if.cmd_ready, busy, done, usr_q, exp_next);
    end
    exp_q = exp_next;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    compared++;
    if (usr_sel !== 2'b00 || usr_sl_r !== 1'b0 || usr_sl_l !== 1'b0 || usr_pi !== 4'b0000 ||
        busy !== 1'b0 || done !== 1'b0 || cmd_if.cmd_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_values: sel=%b slr=%b sll=%b pi=%b busy=%b done=%b ready=%b",
               usr_sel, usr_sl_r, usr_sl_l, usr_pi, busy, done, cmd_if.cmd_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_q = 4'b0000;
  endtask

  task automatic test_reset_mid_shift();
    int done_seen;
    @(negedge clk);
    cmd_if.cmd_op = 2'b01; cmd_if.cmd_cnt = 3'd5; cmd_if.cmd_fill = 1'b1;
    cmd_if.cmd_rot = 1'b0; cmd_if.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    @(negedge clk);
    compared++;
    if (usr_sel !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL mid_shift_sel: got %b want 01", usr_sel);
    end
    rst = 1'b0;
    #1;
    compared++;
    if (usr_sel !== 2'b00 || busy !== 1'b0 || cmd_if.cmd_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL async_reset: sel=%b busy=%b ready=%b want 00 0 1",
               usr_sel, busy, cmd_if.cmd_ready);
    end
    done_seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done !== 1'b0) done_seen++;
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done !== 1'b0) done_seen++;
    end
    compared++;
    if (done_seen != 0) begin
      mismatched++;
      $display("[TB] FAIL reset_no_done: got %0d done cycles want 0", done_seen);
    end
    exp_q = 4'b0000;
  endtask

  task automatic test_load();
    run_cmd(2'b11, 3'd0, 4'b1011, 1'b0, 1'b0, 1'b0, "load_1011");
    compared++;
    if (usr_q !== 4'b1011) begin
      mismatched++;
      $display("[TB] FAIL load_value: got %b want 1011", usr_q);
    end
  endtask

  task automatic test_shift();
    run_cmd(2'b11, 3'd0, 4'b1011, 1'b0, 1'b0, 1'b0, "load_for_shr");
    run_cmd(2'b01, 3'd2, 4'b0000, 1'b0, 1'b0, 1'b0, "shr2_fill0");
    compared++;
    if (usr_q !== 4'b1100) begin
      mismatched++;
      $display("[TB] FAIL shr2_value: got %b want 1100", usr_q);
    end
    run_cmd(2'b11, 3'd0, 4'b1011, 1'b0, 1'b0, 1'b0, "load_for_shl");
    run_cmd(2'b10, 3'd7, 4'b0000, 1'b1, 1'b0, 1'b0, "shl7_fill1");
    compared++;
    if (usr_q !== 4'b1111) begin
      mismatched++;
      $display("[TB] FAIL shl7_value: got %b want 1111", usr_q);
    end
  endtask

  task automatic test_hold();
    run_cmd(2'b11, 3'd0, 4'b0110, 1'b0, 1'b0, 1'b0, "load_for_hold");
    run_cmd(2'b00, 3'd5, 4'b1111, 1'b1, 1'b0, 1'b1, "hold_valid_high");
    run_cmd(2'b01, 3'd0, 4'b1111, 1'b1, 1'b0, 1'b1, "shr_cnt0");
    run_cmd(2'b10, 3'd3, 4'b1111, 1'b1, 1'b0, 1'b1, "shl3_valid_high");
  endtask

  task automatic test_rotate();
    run_cmd(2'b11, 3'd0, 4'b1000, 1'b0, 1'b0, 1'b0, "load_for_rot");
    run_cmd(2'b10, 3'd1, 4'b0000, 1'b0, 1'b1, 1'b0, "shl1_rot");
    run_cmd(2'b11, 3'd0, 4'b1000, 1'b0, 1'b0, 1'b0, "load_for_rotr");
    run_cmd(2'b01, 3'd1, 4'b0000, 1'b0, 1'b1, 1'b0, "shr1_rot");
    run_cmd(2'b11, 3'd0, 4'b1000, 1'b0, 1'b0, 1'b0, "load_for_rot4");
    run_cmd(2'b01, 3'd4, 4'b0000, 1'b0, 1'b1, 1'b0, "shr4_rot");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 4'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), $sformatf("rand_%0d", i));
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    exp_q = 4'b0000;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'b00;
    cmd_if.cmd_cnt   = 3'd0;
    cmd_if.cmd_data  = 4'b0000;
    cmd_if.cmd_fill  = 1'b0;
    cmd_if.cmd_rot   = 1'b0;
    test_reset();
    test_load();
    test_shift();
    test_hold();
    test_rotate();
    test_reset_mid_shift();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
